// File: rtl/pll_rst_pkg.sv
// Shared state encoding, output decode and default timing constants for the
// board PLL reset/lock sequencer.
package pll_rst_pkg;

   localparam int RETRY_W = 4;

   localparam int DEF_PLL_RST_CYCLES = 24;
   localparam int DEF_LOCK_TIMEOUT   = 24000;
   localparam int DEF_LOCK_STABLE    = 256;
   localparam int DEF_SYS_RST_HOLD   = 16;
   localparam int DEF_MAX_RETRY      = 8;
   localparam int DEF_CNT_W          = 16;

   typedef enum logic [5:0] {
      PLL_RST   = 6'b000001,
      WAIT_LOCK = 6'b000010,
      STABLE    = 6'b000100,
      HOLD      = 6'b001000,
      RUN       = 6'b010000,
      FAULT     = 6'b100000
   } state_t;

   typedef struct packed {
      logic pll_reset;
      logic sys_reset;
      logic locked;
      logic fault;
   } out_t;

   // Unknown encodings decode to the safe "everything in reset" set.
   function automatic out_t state_decode(input state_t st);
      out_t o;
      o = '{pll_reset: 1'b1, sys_reset: 1'b1, locked: 1'b0, fault: 1'b0};
      case (st)
         WAIT_LOCK, STABLE: o.pll_reset = 1'b0;
         HOLD: begin
            o.pll_reset = 1'b0;
            o.locked    = 1'b1;
         end
         RUN: begin
            o.pll_reset = 1'b0;
            o.sys_reset = 1'b0;
            o.locked    = 1'b1;
         end
         FAULT:   o.fault = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with synchronous clear to 0.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, then releases
// the system reset; retries on timeout/loss and parks in a sticky fault.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLL_RST   | PLL held in reset for PLL_RST_CYCLES
// WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT for lock
// STABLE    | lock seen, must stay high LOCK_STABLE cycles
// HOLD      | lock qualified, sys_reset held SYS_RST_HOLD more cycles
// RUN       | system out of reset, lock monitored
// FAULT     | MAX_RETRY failed attempts, waits for reset or soft request
module pll_rst_seq
   import pll_rst_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
   parameter int SYS_RST_HOLD   = DEF_SYS_RST_HOLD,
   parameter int MAX_RETRY      = DEF_MAX_RETRY,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               soft_rst_req,
   output logic               pll_reset,
   output logic               sys_reset,
   output logic               locked,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic               fault
);

   localparam logic [CNT_W-1:0]   TC_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TC_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   TC_STABLE  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0]   TC_HOLD    = CNT_W'(SYS_RST_HOLD - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [RETRY_W-1:0] retry_nxt;
   logic               lock_s;
   logic               fail;
   out_t               out_nxt;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry_cnt;
      fail      = 1'b0;
      case (state)
         PLL_RST: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == TC_PLL_RST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (lock_s)                  state_nxt = STABLE;
            else if (cnt == TC_TIMEOUT)  fail      = 1'b1;
         end
         STABLE: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (!lock_s)                 fail      = 1'b1;
            else if (cnt == TC_STABLE)   state_nxt = HOLD;
         end
         HOLD: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (!lock_s)                 fail      = 1'b1;
            else if (cnt == TC_HOLD)     state_nxt = RUN;
         end
         RUN: begin
            // Lock had been achieved, so a later loss is a fresh start.
            if (!lock_s) begin
               state_nxt = PLL_RST;
               retry_nxt = '0;
            end
         end
         FAULT:   ;
         default: state_nxt = PLL_RST;
      endcase

      if (fail) begin
         retry_nxt = retry_cnt + RETRY_W'(1);
         state_nxt = (retry_nxt == RETRY_MAX) ? FAULT : PLL_RST;
      end

      if (soft_rst_req) begin
         state_nxt = PLL_RST;
         retry_nxt = '0;
      end

      if ((state_nxt != state) || soft_rst_req) cnt_nxt = '0;
   end

   // Outputs come from the next state so they line up with the state register.
   assign out_nxt = state_decode(state_nxt);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= PLL_RST;
         cnt       <= '0;
         retry_cnt <= '0;
         pll_reset <= 1'b1;
         sys_reset <= 1'b1;
         locked    <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         retry_cnt <= retry_nxt;
         pll_reset <= out_nxt.pll_reset;
         sys_reset <= out_nxt.sys_reset;
         locked    <= out_nxt.locked;
         fault     <= out_nxt.fault;
      end
   end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: a phase/elapsed-time reference model posts
// expected output-change events; a monitor matches them against the DUT.
module tb_pll_rst_seq;

   localparam int T_RST   = 4;
   localparam int T_TOUT  = 32;
   localparam int T_STAB  = 8;
   localparam int T_HOLD  = 4;
   localparam int N_RETRY = 3;

   localparam int P_RST   = 0;
   localparam int P_WAIT  = 1;
   localparam int P_STAB  = 2;
   localparam int P_HOLD  = 3;
   localparam int P_RUN   = 4;
   localparam int P_FAULT = 5;

   localparam logic [7:0] RESET_TUPLE = 8'b1100_0000;

   typedef struct {
      int         cyc;
      logic [7:0] o;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       pll_lock;
   logic       soft_rst_req;
   logic       pll_reset;
   logic       sys_reset;
   logic       locked;
   logic [3:0] retry_cnt;
   logic       fault;

   ev_t q[$];
   int  cyc;
   int  m_ph;
   int  ncmp;
   int  nfail;

   always #5 clk = ~clk;

   pll_rst_seq #(
      .PLL_RST_CYCLES (T_RST),
      .LOCK_TIMEOUT   (T_TOUT),
      .LOCK_STABLE    (T_STAB),
      .SYS_RST_HOLD   (T_HOLD),
      .MAX_RETRY      (N_RETRY),
      .CNT_W          (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pll_lock     (pll_lock),
      .soft_rst_req (soft_rst_req),
      .pll_reset    (pll_reset),
      .sys_reset    (sys_reset),
      .locked       (locked),
      .retry_cnt    (retry_cnt),
      .fault        (fault)
   );

   function automatic logic [7:0] expect_out(input int ph, input int r);
      logic [3:0] flags;
      case (ph)
         P_WAIT, P_STAB: flags = 4'b0100;
         P_HOLD:         flags = 4'b0110;
         P_RUN:          flags = 4'b0010;
         P_FAULT:        flags = 4'b1101;
         default:        flags = 4'b1100;
      endcase
      return {flags, 4'(r)};
   endfunction

   // Reference model: each phase lasts a fixed number of cycles unless the
   // delayed lock view or a soft request cuts it short.
   initial begin
      int         entered, retries, el, nph;
      logic [1:0] dly;
      logic       lk, failed;
      logic [7:0] last, now_o;
      cyc = 0; m_ph = P_RST; entered = 0; retries = 0; dly = 2'b00;
      last = RESET_TUPLE;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (reset) begin
            m_ph = P_RST; entered = cyc; retries = 0; dly = 2'b00;
         end else begin
            lk = dly[1];
            el = cyc - entered;
            nph = m_ph;
            failed = 1'b0;
            case (m_ph)
               P_RST:  if (el == T_RST) nph = P_WAIT;
               P_WAIT: if (lk) nph = P_STAB; else if (el == T_TOUT) failed = 1'b1;
               P_STAB: if (!lk) failed = 1'b1; else if (el == T_STAB) nph = P_HOLD;
               P_HOLD: if (!lk) failed = 1'b1; else if (el == T_HOLD) nph = P_RUN;
               P_RUN:  if (!lk) begin nph = P_RST; retries = 0; end
               default: ;
            endcase
            if (failed) begin
               retries = retries + 1;
               nph = (retries == N_RETRY) ? P_FAULT : P_RST;
            end
            if (soft_rst_req) begin
               nph = P_RST; retries = 0;
            end
            if (nph != m_ph || soft_rst_req) entered = cyc;
            m_ph = nph;
            dly = {dly[0], pll_lock};
         end
         now_o = expect_out(m_ph, retries);
         if (now_o != last) begin
            q.push_back('{cyc: cyc, o: now_o});
            last = now_o;
         end
      end
   end

   // Monitor: every DUT output change must match the next expected event.
   initial begin
      logic [7:0] prev, cur;
      ev_t e;
      prev = RESET_TUPLE;
      forever begin
         @(negedge clk);
         cur = {pll_reset, sys_reset, locked, fault, retry_cnt};
         if (cur !== prev) begin
            ncmp = ncmp + 1;
            if (q.size() == 0) begin
               nfail = nfail + 1;
               $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
            end else begin
               e = q.pop_front();
               if (e.o !== cur || e.cyc != cyc) begin
                  nfail = nfail + 1;
                  $display("FAIL out_event got=%b@%0d required=%b@%0d", cur, cyc, e.o, e.cyc);
               end
            end
            prev = cur;
         end else if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            ncmp = ncmp + 1;
            nfail = nfail + 1;
            $display("FAIL missed_event got=%b@%0d required=%b@%0d", cur, cyc, e.o, e.cyc);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int dur;
      ncmp = 0; nfail = 0;
      reset = 1'b1; pll_lock = 1'b0; soft_rst_req = 1'b0;
      cycles(3);
      ncmp = ncmp + 1;
      if ({pll_reset, sys_reset, locked, fault, retry_cnt} !== RESET_TUPLE) begin
         nfail = nfail + 1;
         $display("FAIL reset_state got=%b required=%b",
                  {pll_reset, sys_reset, locked, fault, retry_cnt}, RESET_TUPLE);
      end
      reset = 1'b0;

      // nominal lock after a randomised delay
      cycles(T_RST + $urandom_range(6, 12));
      pll_lock = 1'b1;
      cycles(40);

      // lock loss in RUN, then recovery
      pll_lock = 1'b0;
      cycles($urandom_range(3, 10));
      pll_lock = 1'b1;
      cycles(40);

      // soft request on the very edge the synchronised lock falls in RUN
      pll_lock = 1'b0;
      cycles(2);
      soft_rst_req = 1'b1;
      cycles(1);
      soft_rst_req = 1'b0;
      cycles($urandom_range(2, 8));
      pll_lock = 1'b1;
      cycles(40);

      // bounce in STABLE, then timeouts until FAULT
      pll_lock = 1'b0;
      cycles(10);
      pll_lock = 1'b1;
      cycles(7);
      pll_lock = 1'b0;
      cycles(150 + $urandom_range(0, 20));

      // soft request leaves FAULT; lock comes straight back
      soft_rst_req = 1'b1;
      cycles(1);
      soft_rst_req = 1'b0;
      pll_lock = 1'b1;
      for (int i = 0; i < 200 && m_ph != P_HOLD; i++) cycles(1);
      ncmp = ncmp + 1;
      if (m_ph != P_HOLD) begin
         nfail = nfail + 1;
         $display("FAIL reach_hold got=phase%0d required=phase%0d", m_ph, P_HOLD);
      end

      // one-cycle reset while in HOLD
      cycles($urandom_range(0, 2));
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      cycles(50);

      // randomised lock levels with occasional soft requests and resets
      for (int i = 0; i < 40; i++) begin
         pll_lock = ~pll_lock;
         dur = $urandom_range(1, 60);
         for (int j = 0; j < dur; j++) begin
            soft_rst_req = ($urandom_range(0, 49) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            cycles(1);
         end
         soft_rst_req = 1'b0;
         reset = 1'b0;
      end

      cycles(5);
      ncmp = ncmp + 1;
      if (q.size() != 0) begin
         nfail = nfail + 1;
         $display("FAIL pending_events got=%0d required=0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
